// File: rtl/intc_rg_bank.sv
// ----------------------------------------------------------------------------
// intc_rg_bank
//
// Interrupt register bank for the interrupt controller core. Holds the
// per-channel enable, mode (1 = edge, 0 = level) and pending registers,
// synchronises the raw interrupt lines, detects rising edges, and supplies a
// registered "any interrupt" flag plus the lowest-numbered active channel.
//
// Register map (addr_i):
//   0 EN   read/write
//   1 MODE read/write
//   2 PEND read, write-1-to-clear (edge channels only)
//   3 SET  write-1-to-set (edge channels only), reads 0
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   we_i           one-cycle write strobe
//   addr_i         register select
//   be_i           byte enables for writes
//   bs_wdata_i     write data
//   rdata_o        combinational read data for addr_i (zero-extended)
//   irq_i          raw asynchronous interrupt lines
//   rg_en_o        enable register
//   rg_mode_o      mode register
//   pend_o         pending register
//   irq_o          registered OR of pending & enabled
//   irq_id_o       registered lowest active channel; holds while irq_o = 0
// ----------------------------------------------------------------------------
module intc_rg_bank #(
   parameter int              NCH      = 32,
   parameter int              DW       = 32,
   parameter logic [DW-1:0]   EN_RST   = '0,
   parameter logic [DW-1:0]   MODE_RST = '0,
   parameter int              IDW      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [1:0]        addr_i,
   input  logic [DW/8-1:0]   be_i,
   input  logic [DW-1:0]     bs_wdata_i,
   output logic [DW-1:0]     rdata_o,
   input  logic [NCH-1:0]    irq_i,
   output logic [NCH-1:0]    rg_en_o,
   output logic [NCH-1:0]    rg_mode_o,
   output logic [NCH-1:0]    pend_o,
   output logic              irq_o,
   output logic [IDW-1:0]    irq_id_o
);

   localparam logic [1:0] A_EN   = 2'd0;
   localparam logic [1:0] A_MODE = 2'd1;
   localparam logic [1:0] A_PEND = 2'd2;
   localparam logic [1:0] A_SET  = 2'd3;

   logic [NCH-1:0] en_q, mode_q, pend_q;
   logic [NCH-1:0] s1_q, s2_q, s3_q;
   logic           irq_q;
   logic [IDW-1:0] id_q;

   logic [DW-1:0]  lane_mask;
   logic [NCH-1:0] wmask, wdata;
   logic [NCH-1:0] en_d, mode_d, pend_d;
   logic [NCH-1:0] rise, set_bits, clr_bits, edge_nxt, active;
   logic [IDW-1:0] id_d;

   // Expand byte enables to a per-bit mask; only the low NCH bits are ever used.
   always_comb begin
      lane_mask = '0;
      for (int b = 0; b < DW/8; b++) begin
         lane_mask[b*8 +: 8] = {8{be_i[b]}};
      end
   end

   assign wmask = lane_mask[NCH-1:0];
   assign wdata = bs_wdata_i[NCH-1:0];

   // Edge detect uses the two later synchroniser stages so s1 can settle.
   assign rise = s2_q & ~s3_q;

   assign set_bits = (we_i && addr_i == A_SET)  ? (wdata & wmask) : '0;
   assign clr_bits = (we_i && addr_i == A_PEND) ? (wdata & wmask) : '0;

   // Set is OR-ed in after the clear so a coincident set wins.
   assign edge_nxt = (pend_q & ~clr_bits) | rise | set_bits;

   // Level channels simply mirror the synchronised line; edge channels latch.
   assign pend_d = (mode_q & edge_nxt) | (~mode_q & s2_q);

   assign en_d   = (we_i && addr_i == A_EN)   ? ((en_q   & ~wmask) | (wdata & wmask)) : en_q;
   assign mode_d = (we_i && addr_i == A_MODE) ? ((mode_q & ~wmask) | (wdata & wmask)) : mode_q;

   assign active = pend_q & en_q;

   // NOTE: every variable assigned in a combinational block gets a default
   // first, otherwise paths that skip the assignment infer a latch.
   always_comb begin
      id_d = id_q;
      // Scan downwards so the lowest active index is the last one written.
      for (int i = NCH-1; i >= 0; i--) begin
         if (active[i]) id_d = IDW'(i);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q   <= EN_RST[NCH-1:0];
         mode_q <= MODE_RST[NCH-1:0];
         pend_q <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         s3_q   <= '0;
         irq_q  <= 1'b0;
         id_q   <= '0;
      end else begin
         en_q   <= en_d;
         mode_q <= mode_d;
         pend_q <= pend_d;
         s1_q   <= irq_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         irq_q  <= |active;
         id_q   <= id_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      case (addr_i)
         A_EN:    rdata_o[NCH-1:0] = en_q;
         A_MODE:  rdata_o[NCH-1:0] = mode_q;
         A_PEND:  rdata_o[NCH-1:0] = pend_q;
         default: rdata_o = '0;
      endcase
   end

   assign rg_en_o   = en_q;
   assign rg_mode_o = mode_q;
   assign pend_o    = pend_q;
   assign irq_o     = irq_q;
   assign irq_id_o  = id_q;

endmodule

// File: tb/tb_intc_rg_bank.sv
// ----------------------------------------------------------------------------
// tb_intc_rg_bank
//
// Directed, self-checking bench for intc_rg_bank with default parameters
// (NCH = DW = 32, EN_RST = MODE_RST = 0). Inputs change and outputs are
// sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_intc_rg_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [3:0]  be_i;
   logic [31:0] bs_wdata_i;
   logic [31:0] rdata_o;
   logic [31:0] irq_i;
   logic [31:0] rg_en_o;
   logic [31:0] rg_mode_o;
   logic [31:0] pend_o;
   logic        irq_o;
   logic [4:0]  irq_id_o;

   int compared   = 0;
   int mismatched = 0;

   intc_rg_bank dut (
      .clk        (clk),
      .rst        (rst),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .be_i       (be_i),
      .bs_wdata_i (bs_wdata_i),
      .rdata_o    (rdata_o),
      .irq_i      (irq_i),
      .rg_en_o    (rg_en_o),
      .rg_mode_o  (rg_mode_o),
      .pend_o     (pend_o),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) @(negedge clk);
   endtask

   // Write lands on the next rising edge; returns at the following falling edge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      we_i       = 1'b1;
      addr_i     = a;
      bs_wdata_i = d;
      be_i       = be;
      @(negedge clk);
      we_i       = 1'b0;
      bs_wdata_i = '0;
      be_i       = '0;
   endtask

   initial begin
      rst = 1'b1; we_i = 1'b0; addr_i = 2'd0; be_i = '0; bs_wdata_i = '0; irq_i = '0;
      tick(2);
      check("rst_en",   rg_en_o,   32'h0);
      check("rst_mode", rg_mode_o, 32'h0);
      check("rst_pend", pend_o,    32'h0);
      check("rst_irq",  {31'd0, irq_o}, 32'h0);
      check("rst_id",   {27'd0, irq_id_o}, 32'h0);
      rst = 1'b0;
      tick(1);

      // ---- Edge mode, channel 0, two-cycle pulse ----
      wr(2'd1, 32'h1, 4'hF);
      wr(2'd0, 32'h1, 4'hF);
      irq_i[0] = 1'b1;
      tick(2);                              // E0, E1
      irq_i[0] = 1'b0;
      check("edge_pend_after_e1", pend_o, 32'h0);
      tick(1);                              // E2
      check("edge_pend_after_e2", pend_o, 32'h1);
      check("edge_irq_after_e2",  {31'd0, irq_o}, 32'h0);
      tick(1);                              // E3
      check("edge_irq_after_e3",  {31'd0, irq_o}, 32'h1);
      check("edge_id_after_e3",   {27'd0, irq_id_o}, 32'd0);
      wr(2'd2, 32'h1, 4'hF);                // W1C at Ek
      check("w1c_pend_after_ek",  pend_o, 32'h0);
      check("w1c_irq_after_ek",   {31'd0, irq_o}, 32'h1);
      tick(1);
      check("w1c_irq_after_ek1",  {31'd0, irq_o}, 32'h0);

      // ---- Set wins over clear, channel 3 edge mode ----
      wr(2'd1, 32'h9, 4'hF);
      irq_i[3] = 1'b1;
      tick(2);                              // E0, E1
      wr(2'd2, 32'h8, 4'hF);                // W1C coincides with rise at E2
      check("setwins_pend", pend_o, 32'h8);
      wr(2'd2, 32'h8, 4'hF);                // no rise now: clear takes effect
      check("setwins_then_clear", pend_o, 32'h0);
      irq_i[3] = 1'b0;
      tick(2);
      check("edge_fall_no_pend", pend_o, 32'h0);

      // ---- Level mode, channel 5 ----
      wr(2'd0, 32'h20, 4'hF);
      irq_i[5] = 1'b1;
      tick(4);
      check("lvl_pend", pend_o, 32'h20);
      check("lvl_irq",  {31'd0, irq_o}, 32'h1);
      check("lvl_id",   {27'd0, irq_id_o}, 32'd5);
      wr(2'd2, 32'h20, 4'hF);
      check("lvl_w1c_ignored", pend_o, 32'h20);
      irq_i[5] = 1'b0;
      tick(2);                              // E0, E1
      check("lvl_drop_after_2", pend_o, 32'h20);
      tick(1);                              // E2
      check("lvl_drop_after_3", pend_o, 32'h0);
      tick(1);
      check("lvl_drop_irq", {31'd0, irq_o}, 32'h0);
      check("lvl_id_holds", {27'd0, irq_id_o}, 32'd5);

      // ---- Priority and byte enables ----
      wr(2'd1, 32'h0002_0219, 4'hF);        // channels 0,3,4,9,17 edge
      wr(2'd3, 32'h0002_0210, 4'hF);        // software-set 4, 9, 17
      check("prio_pend", pend_o, 32'h0002_0210);
      wr(2'd0, 32'h0, 4'hF);
      wr(2'd0, 32'hFFFF_FFFF, 4'b0110);
      check("be_en", rg_en_o, 32'h00FF_FF00);
      addr_i = 2'd0;
      #1 check("rd_en", rdata_o, 32'h00FF_FF00);
      addr_i = 2'd3;
      #1 check("rd_set_zero", rdata_o, 32'h0);
      addr_i = 2'd1;
      #1 check("rd_mode", rdata_o, 32'h0002_0219);
      tick(1);
      check("prio_irq", {31'd0, irq_o}, 32'h1);
      check("prio_id9", {27'd0, irq_id_o}, 32'd9);
      wr(2'd2, 32'h200, 4'hF);
      tick(1);
      check("prio_id17", {27'd0, irq_id_o}, 32'd17);
      // Disabling keeps pending; re-enable re-asserts irq one cycle later.
      wr(2'd0, 32'h0, 4'hF);
      tick(1);
      check("dis_irq", {31'd0, irq_o}, 32'h0);
      check("dis_pend_kept", pend_o, 32'h0002_0010);
      wr(2'd0, 32'h0002_0000, 4'hF);
      check("reen_irq_same", {31'd0, irq_o}, 32'h0);
      tick(1);
      check("reen_irq_next", {31'd0, irq_o}, 32'h1);

      // ---- Software set, channel 31 ----
      wr(2'd1, 32'h8000_0000, 4'hF);        // others become level, pend follows s2=0
      wr(2'd0, 32'h8000_0000, 4'hF);
      check("sw_pre_pend", pend_o, 32'h0);
      wr(2'd3, 32'h8000_0000, 4'hF);
      check("sw_pend", pend_o, 32'h8000_0000);
      tick(1);
      check("sw_irq", {31'd0, irq_o}, 32'h1);
      check("sw_id31", {27'd0, irq_id_o}, 32'd31);
      wr(2'd2, 32'h8000_0000, 4'hF);
      wr(2'd1, 32'h0, 4'hF);                // all channels level
      wr(2'd3, 32'h8000_0000, 4'hF);
      check("sw_level_ignored", pend_o, 32'h0);

      // ---- Reset mid-run with pend = 0xFF ----
      wr(2'd1, 32'hFF, 4'hF);
      wr(2'd0, 32'hFF, 4'hF);
      wr(2'd3, 32'hFF, 4'hF);
      tick(1);
      check("pre_rst_pend", pend_o, 32'hFF);
      check("pre_rst_irq",  {31'd0, irq_o}, 32'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_pend", pend_o, 32'h0);
      check("mid_rst_irq",  {31'd0, irq_o}, 32'h0);
      check("mid_rst_id",   {27'd0, irq_id_o}, 32'h0);
      check("mid_rst_en",   rg_en_o, 32'h0);
      check("mid_rst_mode", rg_mode_o, 32'h0);
      tick(2);
      rst = 1'b0;
      tick(4);
      check("post_rst_pend", pend_o, 32'h0);
      check("post_rst_irq",  {31'd0, irq_o}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
